// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// FSM state encoding and the store lane-merge helper.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    // Replace the addressed byte or halfword of word with the low bits of wdata.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic        is_half,
                                               input logic [31:0] wdata);
        logic [31:0] merged;
        merged = word;
        if (is_half) begin
            if (lane[1]) begin
                merged[31:16] = wdata[15:0];
            end else begin
                merged[15:0] = wdata[15:0];
            end
        end else begin
            case (lane)
                2'd0:    merged[7:0]   = wdata[7:0];
                2'd1:    merged[15:8]  = wdata[7:0];
                2'd2:    merged[23:16] = wdata[7:0];
                2'd3:    merged[31:24] = wdata[7:0];
                default: merged = word;
            endcase
        end
        return merged;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane select and sign/zero extension of a data-memory word.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] dm_dout,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_rdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lane; halfwords only honour addr_lo[1].
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = dm_dout[7:0];
            2'd1:    byte_s = dm_dout[15:8];
            2'd2:    byte_s = dm_dout[23:16];
            2'd3:    byte_s = dm_dout[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = dm_dout[31:16];
        end else begin
            half_s = dm_dout[15:0];
        end
    end

    // Extend according to width/sign field; unknown encodings return zero.
    always_comb begin
        ld_rdata = 32'h0000_0000;
        case (funct3)
            F3_B:    ld_rdata = {{24{byte_s[7]}}, byte_s};
            F3_BU:   ld_rdata = {24'h00_0000, byte_s};
            F3_H:    ld_rdata = {{16{half_s[15]}}, half_s};
            F3_HU:   ld_rdata = {16'h0000, half_s};
            F3_W:    ld_rdata = dm_dout;
            default: ld_rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit converting RV32I sub-word accesses into word accesses.
// Optional macro MISALIGN_TRAP_EN flags and suppresses misaligned H/W accesses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              stall,
    output logic              misalign,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_dout
);

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [ADDR_W-1:0] held_addr_r;
    logic [DATA_W-1:0] held_word_r;
    logic [ADDR_W-1:0] word_addr_s;
    logic [DATA_W-1:0] ext_s;
    logic              f3_ok_s;
    logic              f3_half_s;
    logic              f3_word_s;
    logic              misalign_s;
    logic              capture_s;

    assign word_addr_s = {req_addr[ADDR_W-1:2], 2'b00};

    // Classify the width field.
    always_comb begin
        f3_ok_s   = 1'b0;
        f3_half_s = 1'b0;
        f3_word_s = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: f3_ok_s = 1'b1;
            F3_H, F3_HU: begin
                f3_ok_s   = 1'b1;
                f3_half_s = 1'b1;
            end
            F3_W: begin
                f3_ok_s   = 1'b1;
                f3_word_s = 1'b1;
            end
            default: f3_ok_s = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign_s = req_valid && !rst && (state_r == ST_IDLE) &&
                        ((f3_half_s && req_addr[0]) ||
                         (f3_word_s && (req_addr[1:0] != 2'b00)));
`else
    assign misalign_s = 1'b0;
`endif

    load_extend u_load_extend (
        .dm_dout  (dm_dout),
        .addr_lo  (req_addr[1:0]),
        .funct3   (req_funct3),
        .ld_rdata (ext_s)
    );

    // Datapath steering and FSM next state.
    always_comb begin
        dm_addr     = word_addr_s;
        dm_din      = req_wdata;
        dm_we       = 1'b0;
        stall       = 1'b0;
        ld_rdata    = '0;
        capture_s   = 1'b0;
        state_nxt_s = ST_IDLE;
        if (state_r == ST_WRITE) begin
            // Second half of read-modify-write; a reset here drops the commit.
            dm_addr = held_addr_r;
            dm_din  = held_word_r;
            dm_we   = !rst;
        end else if (rst || misalign_s || !req_valid || !f3_ok_s) begin
            dm_we = 1'b0;
        end else if (!req_we) begin
            ld_rdata = ext_s;
        end else if (f3_word_s) begin
            dm_we = 1'b1;
        end else if (req_funct3 == F3_B || req_funct3 == F3_H) begin
            stall       = 1'b1;
            capture_s   = 1'b1;
            state_nxt_s = ST_WRITE;
        end else begin
            dm_we = 1'b0;
        end
    end

    assign misalign = misalign_s;

    // FSM state and held store word/address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            held_addr_r <= '0;
            held_word_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                held_addr_r <= word_addr_s;
                held_word_r <= merge_lane(dm_dout, req_addr[1:0], f3_half_s, req_wdata);
            end else begin
                held_addr_r <= held_addr_r;
                held_word_r <= held_word_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard testbench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] ld_rdata;
    logic        stall;
    logic        misalign;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;
    logic        mem_init = 1'b1;

    logic [31:0] mem [0:255];

    typedef struct packed {
        int          id;
        logic [31:0] ld;
        logic        st;
        logic        we;
        logic        mis;
    } cyc_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    cyc_t cyc_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   failures = 0;
    int   vec_id = 0;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ld_rdata   (ld_rdata),
        .stall      (stall),
        .misalign   (misalign),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_we      (dm_we),
        .dm_dout    (dm_dout)
    );

    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8]  <= 32'h1122_3344;
            mem[9]  <= 32'hFFFF_FFFF;
            mem[12] <= 32'hAABB_CCDD;
            mem[16] <= 32'h8899_AABB;
        end else if (dm_we) begin
            mem[dm_addr[9:2]] <= dm_din;
        end
    end

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (vec %0d): got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: per-request cycle expectations and committed writes.
    always @(negedge clk) begin
        cyc_t c;
        wr_t  w;
        if (!rst) begin
            if (req_valid) begin
                if (cyc_q.size() == 0) begin
                    chk("cycle_queue_underflow", -1, 32'd1, 32'd0);
                end else begin
                    c = cyc_q.pop_front();
                    chk("ld_rdata", c.id, ld_rdata, c.ld);
                    chk("stall", c.id, {31'd0, stall}, {31'd0, c.st});
                    chk("dm_we", c.id, {31'd0, dm_we}, {31'd0, c.we});
                    chk("misalign", c.id, {31'd0, misalign}, {31'd0, c.mis});
                end
            end
            if (dm_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", -1, dm_addr, 32'hFFFF_FFFF);
                end else begin
                    w = wr_q.pop_front();
                    chk("dm_addr", -1, dm_addr, w.addr);
                    chk("dm_din", -1, dm_din, w.data);
                end
            end
        end
    end

    task automatic step(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] e_ld, input logic e_st,
                        input logic e_we, input logic e_mis);
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        if (v) begin
            vec_id++;
            cyc_q.push_back('{id: vec_id, ld: e_ld, st: e_st, we: e_we, mis: e_mis});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] e_ld);
        step(1'b1, 1'b0, f3, a, 32'h0, e_ld, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_sw(input logic [31:0] a, input logic [31:0] d);
        wr_q.push_back('{addr: {a[31:2], 2'b00}, data: d});
        step(1'b1, 1'b1, F3_W, a, d, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_sub(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] merged);
        step(1'b1, 1'b1, f3, a, d, 32'h0, 1'b1, 1'b0, 1'b0);
        wr_q.push_back('{addr: {a[31:2], 2'b00}, data: merged});
        step(1'b1, 1'b1, f3, a, d, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a store presented: nothing may be written or stalled.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
        req_addr = 32'h0000_0010; req_wdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dm_we", 0, {31'd0, dm_we}, 32'd0);
        chk("reset_stall", 0, {31'd0, stall}, 32'd0);
        chk("reset_misalign", 0, {31'd0, misalign}, 32'd0);
        @(posedge clk);
        #1;
        mem_init = 1'b0;
        rst = 1'b0;
        req_valid = 1'b0;
        step(1'b0, 1'b0, F3_B, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Loads from 0x8899AABB at 0x40.
        do_load(F3_B,  32'h0000_0041, 32'hFFFF_FFAA);
        do_load(F3_BU, 32'h0000_0041, 32'h0000_00AA);
        do_load(F3_H,  32'h0000_0042, 32'hFFFF_8899);
        do_load(F3_HU, 32'h0000_0042, 32'h0000_8899);
        do_load(F3_B,  32'h0000_0043, 32'hFFFF_FF88);
        do_load(F3_W,  32'h0000_0040, 32'h8899_AABB);

        do_sw(32'h0000_0010, 32'hDEAD_BEEF);
        do_sub(F3_B, 32'h0000_0022, 32'h0000_0055, 32'h1155_3344);
        do_sub(F3_H, 32'h0000_0024, 32'h0000_CAFE, 32'hFFFF_CAFE);
        do_load(F3_W, 32'h0000_0024, 32'hFFFF_CAFE);

        // Back-to-back byte stores to one word; the second must see the first.
        do_sub(F3_B, 32'h0000_0020, 32'h0000_0001, 32'h1155_3301);
        do_sub(F3_B, 32'h0000_0021, 32'h0000_0002, 32'h1155_0201);
        do_load(F3_W, 32'h0000_0020, 32'h1155_0201);

        // Reserved funct3: no write, zero result, no stall.
        step(1'b1, 1'b0, 3'b011, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'b011, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, F3_BU, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);

        // Idle request: zero load result.
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h0000_0040;
        @(negedge clk);
        chk("idle_ld_rdata", 0, ld_rdata, 32'h0);
        chk("idle_stall", 0, {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;

`ifdef MISALIGN_TRAP_EN
        step(1'b1, 1'b0, F3_W, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, F3_H, 32'h0000_0041, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, F3_H, 32'h0000_0041, 32'h0000_1111, 32'h0, 1'b0, 1'b0, 1'b1);
`else
        do_load(F3_W, 32'h0000_0013, 32'hDEAD_BEEF);
        do_load(F3_H, 32'h0000_0041, 32'hFFFF_AABB);
`endif

        // Reset during the WRITE cycle of a byte store drops the write.
        step(1'b1, 1'b1, F3_B, 32'h0000_0031, 32'h0000_0077, 32'h0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_write_dm_we", 0, {31'd0, dm_we}, 32'd0);
        chk("rst_write_stall", 0, {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, F3_B, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_write_mem", 0, mem[12], 32'hAABB_CCDD);
        do_load(F3_W, 32'h0000_0030, 32'hAABB_CCDD);

        step(1'b0, 1'b0, F3_B, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("cycle_queue_empty", 0, cyc_q.size(), 32'd0);
        chk("write_queue_empty", 0, wr_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
